// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin arbiter driving the I/Q channel through header, payload and rest gap
module tx_frame_scheduler #(
    parameter int HEAD_LEN  = 5,
    parameter int FRAME_LEN = 32,
    parameter int REST_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sched_en_i,
    input  logic              req_a_i,
    input  logic              req_b_i,
    input  logic signed [3:0] a_i_i,
    input  logic signed [3:0] a_q_i,
    input  logic signed [3:0] b_i_i,
    input  logic signed [3:0] b_q_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic              sym_rd_o,
    output logic              tx_en_o,
    output logic signed [3:0] tx_i_o,
    output logic signed [3:0] tx_q_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int FRAME_CYC = HEAD_LEN + FRAME_LEN;
    localparam int PW = $clog2(FRAME_CYC > REST_LEN ? FRAME_CYC : REST_LEN);
    localparam logic [PW-1:0] HEAD_END  = PW'(HEAD_LEN - 1);
    localparam logic [PW-1:0] RD_LAST   = PW'(FRAME_CYC - 2);
    localparam logic [PW-1:0] FRAME_END = PW'(FRAME_CYC - 1);
    localparam logic [PW-1:0] REST_END  = PW'(REST_LEN - 1);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, REST} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              last_b_q, last_b_d;
    logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic              sym_rd_q, sym_rd_d, tx_en_q, tx_en_d;
    logic              busy_q, busy_d, frame_done_q, frame_done_d;
    logic signed [3:0] tx_i_q, tx_i_d, tx_q_q, tx_q_d;

    // State, position counter, arbitration history and every output are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            last_b_q     <= 1'b1;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            sym_rd_q     <= 1'b0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            tx_i_q       <= '0;
            tx_q_q       <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            last_b_q     <= last_b_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            sym_rd_q     <= sym_rd_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            tx_i_q       <= tx_i_d;
            tx_q_q       <= tx_q_d;
        end
    end

    // Next state plus next output values; outputs derive from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        last_b_d = last_b_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        case (state_q)
            IDLE: if (sched_en_i && (req_a_i || req_b_i)) begin
                state_d = HEAD;
                pos_d   = '0;
                gnt_a_d = req_a_i && (!req_b_i || last_b_q);
                gnt_b_d = req_b_i && (!req_a_i || !last_b_q);
            end
            HEAD: begin
                pos_d   = pos_q + 1'b1;
                state_d = pos_q == HEAD_END ? PAYLOAD : HEAD;
            end
            PAYLOAD: if (pos_q == FRAME_END) begin
                state_d  = REST;
                pos_d    = '0;
                last_b_d = gnt_b_q;
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
            REST: begin
                pos_d   = pos_q == REST_END ? '0 : pos_q + 1'b1;
                state_d = pos_q == REST_END ? IDLE : REST;
            end
            default: state_d = IDLE;
        endcase
        tx_en_d      = state_d == HEAD || state_d == PAYLOAD;
        sym_rd_d     = tx_en_d && pos_d >= HEAD_END && pos_d <= RD_LAST;
        busy_d       = state_d != IDLE;
        frame_done_d = state_q == PAYLOAD && state_d == REST;
        tx_i_d       = sym_rd_q ? (gnt_a_q ? a_i_i : b_i_i) : (state_d == PAYLOAD ? tx_i_q : '0);
        tx_q_d       = sym_rd_q ? (gnt_a_q ? a_q_i : b_q_i) : (state_d == PAYLOAD ? tx_q_q : '0);
    end

    assign gnt_a_o      = gnt_a_q;
    assign gnt_b_o      = gnt_b_q;
    assign sym_rd_o     = sym_rd_q;
    assign tx_en_o      = tx_en_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign tx_i_o       = tx_i_q;
    assign tx_q_o       = tx_q_q;
endmodule
